// File: rtl/cnt_en_gen_pkg.sv
// Shared constants and state encoding for the cnt_en_gen enable-pulse generator.
package cnt_en_gen_pkg;

  localparam int DEF_DIV_WIDTH   = 8;
  localparam int DEF_BURST_WIDTH = 7;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_RUN  = RUN,
    ST_DONE = DONE
  } state_e;

endpackage

// File: rtl/cnt_en_presc.sv
// Period prescaler: counts 0..div and flags terminal count; clr restarts the
// count from zero in the same cycle so the start cycle itself is count 0.
module cnt_en_presc
  import cnt_en_gen_pkg::*;
#(
  parameter int DIV_WIDTH = DEF_DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tc
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] cnt_cur;

  assign cnt_cur = clr ? '0 : cnt_q;
  assign tc      = (cnt_cur == div);

  // NOTE: sequential state uses <= so every register samples pre-edge values;
  // a blocking = here would let later statements see the updated count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr || en) begin
      cnt_q <= tc ? '0 : DIV_WIDTH'(cnt_cur + 1'b1);
    end
  end

endmodule

// File: rtl/cnt_en_gen.sv
// Enable-pulse generator: after start, one en_o pulse every div+1 cycles,
// for burst pulses (or until stop when burst is zero).
module cnt_en_gen
  import cnt_en_gen_pkg::*;
#(
  parameter int DIV_WIDTH   = DEF_DIV_WIDTH,
  parameter int BURST_WIDTH = DEF_BURST_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic [DIV_WIDTH-1:0]   div_i,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic                   en_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [BURST_WIDTH-1:0] pulse_cnt_o
);

  state_e                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   div_q;
  logic [BURST_WIDTH-1:0] burst_q;
  logic [BURST_WIDTH-1:0] pulse_cnt_d;
  logic                   start_acc;
  logic                   issue;
  logic                   last_pulse;
  logic                   tc;
  logic [DIV_WIDTH-1:0]   presc_div;

  // On the start cycle the prescaler must compare against the incoming
  // div_i, since div_q has not been loaded yet.
  assign presc_div = start_acc ? div_i : div_q;

  cnt_en_presc #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_presc (
    .clk (clk),
    .rst (rst),
    .clr (start_acc),
    .en  (state_q == ST_RUN),
    .div (presc_div),
    .tc  (tc)
  );

  // The pulse currently on en_o is the final one of a finite burst.
  assign last_pulse = en_o && (burst_q != '0) && (pulse_cnt_o == burst_q);

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i && !stop_i) begin
          start_acc = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop_i) begin
          state_d = ST_IDLE;
        end else if (last_pulse) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    issue       = (state_d == ST_RUN) && tc;
    pulse_cnt_d = (start_acc ? '0 : pulse_cnt_o) + BURST_WIDTH'(issue);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      burst_q     <= '0;
      en_o        <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      pulse_cnt_o <= '0;
    end else begin
      state_q     <= state_d;
      en_o        <= issue;
      busy_o      <= (state_d == ST_RUN);
      done_o      <= (state_d == ST_DONE);
      pulse_cnt_o <= pulse_cnt_d;
      if (start_acc) begin
        div_q   <= div_i;
        burst_q <= burst_i;
      end
    end
  end

endmodule
